// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_pkg                                                         |
// | Purpose  : Shared PS/2 receiver types and constants: frame geometry,       |
// |            deframer state encoding, scan byte type, odd-parity helper.     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    STOP = 2'd2
  } ps2_rx_state_e;

  typedef logic [PS2_DATA_BITS-1:0] ps2_byte_t;

  // Odd parity over data plus parity bit: an odd number of ones is good.
  function automatic logic ps2_parity_ok(input ps2_byte_t d, input logic p);
    return ^{d, p};
  endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_rx_fifo_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_frame_rx                                                    |
// | Purpose  : Synchronises the PS/2 pins, detects ps2_clk falling edges,      |
// |            deframes 11-bit device-to-host frames and runs a watchdog that  |
// |            aborts frames stalled for TIMEOUT_CYCLES clk cycles.            |
// | Ports    : clk, rst (async, active-high)                                   |
// |            ps2_clk, ps2_data    asynchronous PS/2 pins                     |
// |            byte_valid           1-cycle pulse, rx_byte holds a good byte   |
// |            rx_byte              received byte                              |
// |            parity_evt           1-cycle pulse, frame dropped for parity    |
// |            frame_evt            1-cycle pulse, frame dropped for stop bit  |
// |            timeout_evt          1-cycle pulse, frame aborted by watchdog   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ps2_clk,
  input  logic      ps2_data,
  output logic      byte_valid,
  output ps2_byte_t rx_byte,
  output logic      parity_evt,
  output logic      frame_evt,
  output logic      timeout_evt
);

  localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] c_LAST_BIT = 4'(PS2_DATA_BITS);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  ps2_rx_state_e          r_state, w_state_nxt;
  logic [3:0]             r_bitcnt, w_bitcnt_nxt;
  logic [PS2_DATA_BITS:0] r_shift, w_shift_nxt;  // {parity, data[7:0]} once full
  logic [c_WD_W-1:0]      r_wd, w_wd_nxt;

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;
  logic w_timeout;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;
  // A fall in the terminal cycle is real bus activity and wins over the watchdog.
  assign w_timeout = (r_wd == c_WD_LAST) && !w_fall;
  assign rx_byte   = r_shift[PS2_DATA_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_wd        <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
      r_state     <= w_state_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_wd        <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_wd_nxt     = r_wd + 1'b1;
    byte_valid   = 1'b0;
    parity_evt   = 1'b0;
    frame_evt    = 1'b0;
    timeout_evt  = 1'b0;

    if (w_fall || r_state == IDLE) begin
      w_wd_nxt = '0;
    end

    case (r_state)
      IDLE: begin
        // A fall with data high is line noise, not a start bit.
        if (w_fall && !w_data_s) begin
          w_state_nxt  = RECV;
          w_bitcnt_nxt = '0;
        end
      end
      RECV: begin
        if (w_timeout) begin
          w_state_nxt = IDLE;
          timeout_evt = 1'b1;
        end else if (w_fall) begin
          w_shift_nxt = {w_data_s, r_shift[PS2_DATA_BITS:1]};
          if (r_bitcnt == c_LAST_BIT) begin
            w_state_nxt = STOP;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_timeout) begin
          w_state_nxt = IDLE;
          timeout_evt = 1'b1;
        end else if (w_fall) begin
          w_state_nxt = IDLE;
          // Framing error masks a simultaneous parity error.
          if (!w_data_s) begin
            frame_evt = 1'b1;
          end else if (!ps2_parity_ok(r_shift[PS2_DATA_BITS-1:0], r_shift[PS2_DATA_BITS])) begin
            parity_evt = 1'b1;
          end else begin
            byte_valid = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule : ps2_frame_rx
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_rx_fifo                                                     |
// | Purpose  : PS/2 device-to-host receiver with a scan-byte FIFO read over a  |
// |            valid/ready port, occupancy level and sticky error flags.       |
// | Ports    : clk, rst (async, active-high)                                   |
// |            ps2_clk, ps2_data    asynchronous PS/2 pins                     |
// |            m_data/m_valid/m_ready  FIFO head, valid/ready handshake        |
// |            level                current FIFO occupancy                     |
// |            overflow, parity_err, frame_err, timeout_err  sticky flags      |
// |            err_clr              pulse clearing the sticky flags            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_PTR_W = c_AW + 1;

  logic      w_byte_valid;
  ps2_byte_t w_rx_byte;
  logic      w_parity_evt;
  logic      w_frame_evt;
  logic      w_timeout_evt;

  ps2_byte_t          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic               r_overflow;
  logic               r_parity_err;
  logic               r_frame_err;
  logic               r_timeout_err;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_overflow_evt;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .byte_valid  (w_byte_valid),
    .rx_byte     (w_rx_byte),
    .parity_evt  (w_parity_evt),
    .frame_evt   (w_frame_evt),
    .timeout_evt (w_timeout_evt)
  );

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop   = m_valid && m_ready;
  // A same-cycle pop frees the slot the push needs, so full only blocks a lone push.
  assign w_push         = w_byte_valid && (!w_full || w_pop);
  assign w_overflow_evt = w_byte_valid && w_full && !w_pop;

  assign m_valid = !w_empty;
  assign m_data  = m_valid ? r_mem[r_rd_ptr[c_AW-1:0]] : 8'h00;
  assign level   = r_wr_ptr - r_rd_ptr;

  assign overflow    = r_overflow;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign timeout_err = r_timeout_err;

  // Storage needs no reset: entries are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= w_rx_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_overflow    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Set dominates clear so an event coincident with err_clr is not lost.
      r_overflow    <= (r_overflow    & ~err_clr) | w_overflow_evt;
      r_parity_err  <= (r_parity_err  & ~err_clr) | w_parity_evt;
      r_frame_err   <= (r_frame_err   & ~err_clr) | w_frame_evt;
      r_timeout_err <= (r_timeout_err & ~err_clr) | w_timeout_evt;
    end
  end

endmodule : ps2_rx_fifo
`default_nettype wire
